// File: rtl/alu_issue_stage_if.sv
// Command and result handshake bundle between an issuing master and alu_issue_stage.
interface alu_issue_stage_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_s;
   logic [2:0] cmd_a;
   logic [2:0] cmd_b;
   logic       res_valid;
   logic       res_ready;
   logic [4:0] res_sm;
   logic [4:0] res_data;
   logic       res_sf;
   logic       res_zf;
   logic       res_dzf;

   modport master (
      output cmd_valid, cmd_s, cmd_a, cmd_b, res_ready,
      input  cmd_ready, res_valid, res_sm, res_data, res_sf, res_zf, res_dzf
   );

   modport slave (
      input  cmd_valid, cmd_s, cmd_a, cmd_b, res_ready,
      output cmd_ready, res_valid, res_sm, res_data, res_sf, res_zf, res_dzf
   );
endinterface

// File: rtl/alu_issue_stage.sv
// Issue stage wrapping an external sign-magnitude ALU: registers operands, captures
// the result one cycle later, converts it to two's complement and counts completions.
module alu_issue_stage #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_issue_stage_if.slave bus,
   output logic [2:0]       alu_a,
   output logic [2:0]       alu_b,
   output logic [1:0]       alu_s,
   input  logic [4:0]       alu_r,
   input  logic             alu_sf,
   input  logic             alu_zf,
   input  logic             alu_dzf,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] op_cnt,
   output logic [CNT_W-1:0] dz_cnt
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t     state, state_nxt;
   logic       cmd_ready, res_valid;
   logic       accept, res_hs;
   logic [4:0] conv;
   logic [4:0] res_sm_q, res_data_q;
   logic       res_sf_q, res_zf_q, res_dzf_q;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      res_valid = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (bus.cmd_valid) state_nxt = EXEC;
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            res_valid = 1'b1;
            if (bus.res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = bus.cmd_valid && cmd_ready;
   assign res_hs = res_valid && bus.res_ready;

   // Both signed zeros and divide-by-zero collapse to 0; otherwise negate {0,mag} when sign is set.
   always_comb begin
      conv = '0;
      if (!alu_dzf && alu_r[3:0] != 4'd0) begin
         if (alu_r[4]) conv = 5'd0 - {1'b0, alu_r[3:0]};
         else          conv = {1'b0, alu_r[3:0]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_s      <= '0;
         res_sm_q   <= '0;
         res_data_q <= '0;
         res_sf_q   <= 1'b0;
         res_zf_q   <= 1'b0;
         res_dzf_q  <= 1'b0;
      end else begin
         if (accept) begin
            alu_s <= bus.cmd_s;
            alu_a <= (bus.cmd_a == 3'b100) ? 3'b000 : bus.cmd_a;
            alu_b <= (bus.cmd_b == 3'b100) ? 3'b000 : bus.cmd_b;
         end
         if (state == EXEC) begin
            res_sm_q   <= alu_r;
            res_data_q <= conv;
            res_sf_q   <= alu_sf & ~alu_zf;
            res_zf_q   <= alu_zf;
            res_dzf_q  <= alu_dzf;
         end
      end
   end

   // Clear wins over a same-edge increment.
   always_ff @(posedge clk) begin
      if (!rst_n || clr_cnt) begin
         op_cnt <= '0;
         dz_cnt <= '0;
      end else if (res_hs) begin
         if (op_cnt != CNT_MAX)              op_cnt <= op_cnt + 1'b1;
         if (res_dzf_q && dz_cnt != CNT_MAX) dz_cnt <= dz_cnt + 1'b1;
      end
   end

   assign bus.cmd_ready = cmd_ready;
   assign bus.res_valid = res_valid;
   assign bus.res_sm    = res_sm_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_sf    = res_sf_q;
   assign bus.res_zf    = res_zf_q;
   assign bus.res_dzf   = res_dzf_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural sign-magnitude ALU on the alu_* side.
module tb_alu_issue_stage;
   localparam int unsigned CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [2:0]       alu_a, alu_b;
   logic [1:0]       alu_s;
   logic [4:0]       alu_r;
   logic             alu_sf, alu_zf, alu_dzf;
   logic             clr_cnt;
   logic [CNT_W-1:0] op_cnt, dz_cnt;

   logic       ovr;
   logic [4:0] ovr_r;
   logic       ovr_sf, ovr_zf, ovr_dzf;

   int passed = 0;
   int total  = 0;
   int exp_op = 0;
   int exp_dz = 0;

   alu_issue_stage_if bus ();

   alu_issue_stage #(.CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .alu_a   (alu_a),
      .alu_b   (alu_b),
      .alu_s   (alu_s),
      .alu_r   (alu_r),
      .alu_sf  (alu_sf),
      .alu_zf  (alu_zf),
      .alu_dzf (alu_dzf),
      .clr_cnt (clr_cnt),
      .op_cnt  (op_cnt),
      .dz_cnt  (dz_cnt)
   );

   always #5 clk = ~clk;

   // External ALU: signed arithmetic on sign-magnitude operands, div truncates toward zero.
   int av, bv, rv, mv;
   always_comb begin
      av      = alu_a[2] ? -int'(alu_a[1:0]) : int'(alu_a[1:0]);
      bv      = alu_b[2] ? -int'(alu_b[1:0]) : int'(alu_b[1:0]);
      rv      = 0;
      mv      = 0;
      alu_r   = '0;
      alu_sf  = 1'b0;
      alu_zf  = 1'b0;
      alu_dzf = 1'b0;
      if (ovr) begin
         alu_r   = ovr_r;
         alu_sf  = ovr_sf;
         alu_zf  = ovr_zf;
         alu_dzf = ovr_dzf;
      end else begin
         case (alu_s)
            2'b00: rv = av + bv;
            2'b01: rv = av - bv;
            2'b10: rv = av * bv;
            default: begin
               if (bv == 0) alu_dzf = 1'b1;
               else         rv = av / bv;
            end
         endcase
         if (alu_dzf) begin
            alu_r = 5'b00111;
         end else begin
            mv     = (rv < 0) ? -rv : rv;
            alu_r  = {rv < 0, 4'(mv)};
            alu_sf = rv < 0;
            alu_zf = mv == 0;
         end
      end
   end

   // Drives one command from IDLE and returns at the negedge inside EXEC.
   task automatic issue(input logic [1:0] s, input logic [2:0] a, input logic [2:0] b);
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_s     = s;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      total++; if (bus.cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got %b exp 1", bus.cmd_ready); else passed++;
      total++; if (bus.res_valid !== 1'b0) $display("FAIL rst_res_valid got %b exp 0", bus.res_valid); else passed++;
      total++; if ({alu_a, alu_b, alu_s} !== 8'h00) $display("FAIL rst_alu_regs got %h exp 00", {alu_a, alu_b, alu_s}); else passed++;
      total++; if ({bus.res_sm, bus.res_data} !== 10'h000) $display("FAIL rst_res got %h exp 000", {bus.res_sm, bus.res_data}); else passed++;
      total++; if ({bus.res_sf, bus.res_zf, bus.res_dzf} !== 3'b000) $display("FAIL rst_flags got %b exp 000", {bus.res_sf, bus.res_zf, bus.res_dzf}); else passed++;
      total++; if ({op_cnt, dz_cnt} !== 16'h0000) $display("FAIL rst_counters got %h exp 0000", {op_cnt, dz_cnt}); else passed++;
   endtask

   task automatic test_add;
      issue(2'b00, 3'b011, 3'b110);
      total++; if ({alu_s, alu_a, alu_b} !== 8'b00_011_110) $display("FAIL add_alu_in got %b exp 00011110", {alu_s, alu_a, alu_b}); else passed++;
      total++; if ({bus.cmd_ready, bus.res_valid} !== 2'b00) $display("FAIL add_exec_hs got %b exp 00", {bus.cmd_ready, bus.res_valid}); else passed++;
      @(negedge clk);
      total++; if (bus.res_valid !== 1'b1) $display("FAIL add_latency got %b exp 1", bus.res_valid); else passed++;
      total++; if (bus.res_sm !== 5'b00001) $display("FAIL add_sm got %b exp 00001", bus.res_sm); else passed++;
      total++; if (bus.res_data !== 5'b00001) $display("FAIL add_data got %b exp 00001", bus.res_data); else passed++;
      total++; if ({bus.res_sf, bus.res_zf, bus.res_dzf} !== 3'b000) $display("FAIL add_flags got %b exp 000", {bus.res_sf, bus.res_zf, bus.res_dzf}); else passed++;
      @(negedge clk);
      exp_op++;
      total++; if ({bus.cmd_ready, bus.res_valid} !== 2'b10) $display("FAIL add_done_hs got %b exp 10", {bus.cmd_ready, bus.res_valid}); else passed++;
      total++; if (op_cnt !== 8'(exp_op)) $display("FAIL add_op_cnt got %0d exp %0d", op_cnt, exp_op); else passed++;
   endtask

   task automatic test_mul_neg;
      issue(2'b10, 3'b111, 3'b011);
      @(negedge clk);
      total++; if (bus.res_sm !== 5'b11001) $display("FAIL mul_sm got %b exp 11001", bus.res_sm); else passed++;
      total++; if (bus.res_data !== 5'b10111) $display("FAIL mul_data got %b exp 10111", bus.res_data); else passed++;
      total++; if ({bus.res_sf, bus.res_zf} !== 2'b10) $display("FAIL mul_flags got %b exp 10", {bus.res_sf, bus.res_zf}); else passed++;
      @(negedge clk);
      exp_op++;
   endtask

   task automatic test_div_zero;
      issue(2'b11, 3'b010, 3'b000);
      @(negedge clk);
      total++; if (bus.res_dzf !== 1'b1) $display("FAIL dz_flag got %b exp 1", bus.res_dzf); else passed++;
      total++; if (bus.res_data !== 5'b00000) $display("FAIL dz_data got %b exp 00000", bus.res_data); else passed++;
      total++; if (bus.res_sm !== 5'b00111) $display("FAIL dz_sm got %b exp 00111", bus.res_sm); else passed++;
      @(negedge clk);
      exp_op++; exp_dz++;
      total++; if (op_cnt !== 8'(exp_op)) $display("FAIL dz_op_cnt got %0d exp %0d", op_cnt, exp_op); else passed++;
      total++; if (dz_cnt !== 8'(exp_dz)) $display("FAIL dz_dz_cnt got %0d exp %0d", dz_cnt, exp_dz); else passed++;
   endtask

   task automatic test_neg_zero;
      issue(2'b01, 3'b100, 3'b001);
      total++; if ({alu_a, alu_b} !== 6'b000_001) $display("FAIL nz_a_in got %b exp 000001", {alu_a, alu_b}); else passed++;
      @(negedge clk);
      total++; if (bus.res_sm !== 5'b10001) $display("FAIL nz_sm got %b exp 10001", bus.res_sm); else passed++;
      total++; if (bus.res_data !== 5'b11111) $display("FAIL nz_data got %b exp 11111", bus.res_data); else passed++;
      total++; if (bus.res_sf !== 1'b1) $display("FAIL nz_sf got %b exp 1", bus.res_sf); else passed++;
      @(negedge clk);
      exp_op++;
      issue(2'b10, 3'b011, 3'b100);
      total++; if ({alu_a, alu_b} !== 6'b011_000) $display("FAIL nz_b_in got %b exp 011000", {alu_a, alu_b}); else passed++;
      @(negedge clk);
      total++; if ({bus.res_sm, bus.res_data} !== 10'b00000_00000) $display("FAIL nz_mul_res got %b exp 0", {bus.res_sm, bus.res_data}); else passed++;
      total++; if ({bus.res_sf, bus.res_zf} !== 2'b01) $display("FAIL nz_mul_flags got %b exp 01", {bus.res_sf, bus.res_zf}); else passed++;
      @(negedge clk);
      exp_op++;
   endtask

   task automatic test_alu_edges;
      ovr = 1'b1; ovr_r = 5'b10000; ovr_sf = 1'b1; ovr_zf = 1'b1; ovr_dzf = 1'b0;
      issue(2'b00, 3'b000, 3'b000);
      @(negedge clk);
      total++; if (bus.res_sm !== 5'b10000) $display("FAIL negz_sm got %b exp 10000", bus.res_sm); else passed++;
      total++; if (bus.res_data !== 5'b00000) $display("FAIL negz_data got %b exp 00000", bus.res_data); else passed++;
      total++; if ({bus.res_sf, bus.res_zf} !== 2'b01) $display("FAIL negz_flags got %b exp 01", {bus.res_sf, bus.res_zf}); else passed++;
      @(negedge clk);
      exp_op++;
      ovr_r = 5'b01001; ovr_sf = 1'b0; ovr_zf = 1'b0;
      issue(2'b10, 3'b011, 3'b011);
      @(negedge clk);
      total++; if (bus.res_data !== 5'b01001) $display("FAIL pos9_data got %b exp 01001", bus.res_data); else passed++;
      @(negedge clk);
      exp_op++;
      ovr = 1'b0;
   endtask

   task automatic test_backpressure;
      bus.res_ready = 1'b0;
      issue(2'b01, 3'b011, 3'b001);
      @(negedge clk);
      total++; if (bus.res_data !== 5'b00010) $display("FAIL bp_data got %b exp 00010", bus.res_data); else passed++;
      for (int i = 0; i < 5; i++) begin
         bus.cmd_valid = 1'b1; bus.cmd_s = 2'b00; bus.cmd_a = 3'b001; bus.cmd_b = 3'b001;
         @(negedge clk);
         total++; if ({bus.res_valid, bus.cmd_ready} !== 2'b10) $display("FAIL bp_hs[%0d] got %b exp 10", i, {bus.res_valid, bus.cmd_ready}); else passed++;
         total++; if ({bus.res_sm, bus.res_data} !== 10'b00010_00010) $display("FAIL bp_hold[%0d] got %b exp 0001000010", i, {bus.res_sm, bus.res_data}); else passed++;
         total++; if (alu_a !== 3'b011) $display("FAIL bp_alu_a[%0d] got %b exp 011", i, alu_a); else passed++;
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      exp_op++;
      total++; if ({bus.res_valid, bus.cmd_ready} !== 2'b01) $display("FAIL bp_release got %b exp 01", {bus.res_valid, bus.cmd_ready}); else passed++;
      total++; if (alu_a !== 3'b011) $display("FAIL bp_no_same_cycle got %b exp 011", alu_a); else passed++;
      total++; if (op_cnt !== 8'(exp_op)) $display("FAIL bp_op_cnt got %0d exp %0d", op_cnt, exp_op); else passed++;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      total++; if ({alu_a, bus.cmd_ready} !== 4'b001_0) $display("FAIL b2b_accept got %b exp 0010", {alu_a, bus.cmd_ready}); else passed++;
      @(negedge clk);
      total++; if (bus.res_data !== 5'b00010) $display("FAIL b2b_data got %b exp 00010", bus.res_data); else passed++;
      @(negedge clk);
      exp_op++;
   endtask

   task automatic test_counters;
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      exp_op = 0; exp_dz = 0;
      total++; if ({op_cnt, dz_cnt} !== 16'h0000) $display("FAIL clr_idle got %h exp 0000", {op_cnt, dz_cnt}); else passed++;
      for (int i = 0; i < 254; i++) begin
         issue(2'b11, 3'b010, 3'b000);
         repeat (2) @(negedge clk);
      end
      total++; if ({op_cnt, dz_cnt} !== 16'hFEFE) $display("FAIL cnt_254 got %h exp fefe", {op_cnt, dz_cnt}); else passed++;
      for (int i = 0; i < 6; i++) begin
         issue(2'b11, 3'b010, 3'b000);
         repeat (2) @(negedge clk);
      end
      total++; if ({op_cnt, dz_cnt} !== 16'hFFFF) $display("FAIL cnt_sat got %h exp ffff", {op_cnt, dz_cnt}); else passed++;
      issue(2'b11, 3'b001, 3'b000);
      @(negedge clk);
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      total++; if ({op_cnt, dz_cnt} !== 16'h0000) $display("FAIL clr_prio got %h exp 0000", {op_cnt, dz_cnt}); else passed++;
      total++; if ({bus.cmd_ready, bus.res_valid} !== 2'b10) $display("FAIL clr_fsm got %b exp 10", {bus.cmd_ready, bus.res_valid}); else passed++;
   endtask

   task automatic test_reset_mid;
      issue(2'b00, 3'b001, 3'b001);
      repeat (2) @(negedge clk);
      total++; if (op_cnt !== 8'd1) $display("FAIL pre_rst_op got %0d exp 1", op_cnt); else passed++;
      issue(2'b10, 3'b111, 3'b011);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      total++; if ({bus.cmd_ready, bus.res_valid} !== 2'b10) $display("FAIL midrst_hs got %b exp 10", {bus.cmd_ready, bus.res_valid}); else passed++;
      total++; if ({bus.res_sm, bus.res_data} !== 10'h000) $display("FAIL midrst_res got %h exp 000", {bus.res_sm, bus.res_data}); else passed++;
      total++; if ({op_cnt, dz_cnt} !== 16'h0000) $display("FAIL midrst_cnt got %h exp 0000", {op_cnt, dz_cnt}); else passed++;
      total++; if ({alu_a, alu_s} !== 5'b000_00) $display("FAIL midrst_alu got %b exp 00000", {alu_a, alu_s}); else passed++;
      @(negedge clk);
      total++; if (bus.res_valid !== 1'b0) $display("FAIL midrst_no_result got %b exp 0", bus.res_valid); else passed++;
   endtask

   initial begin
      rst_n = 1'b0; clr_cnt = 1'b0; ovr = 1'b0;
      ovr_r = '0; ovr_sf = 1'b0; ovr_zf = 1'b0; ovr_dzf = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd_s = '0; bus.cmd_a = '0; bus.cmd_b = '0;
      bus.res_ready = 1'b1;
      test_reset();
      test_add();
      test_mul_neg();
      test_div_zero();
      test_neg_zero();
      test_alu_edges();
      test_backpressure();
      test_counters();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached after %0d/%0d checks", passed, total);
      $fatal(1);
   end

endmodule
